// File: rtl/lvds_input_common.sv
// Shared types and constants for the AXI-Lite register write slave.
// Holds the FSM encoding, response codes and register index names.
package lvds_input_common;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HAVE_AW = 2'd1,
        HAVE_W  = 2'd2,
        RESP    = 2'd3
    } wr_state_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    localparam int REG_IDX_0 = 0;
    localparam int REG_IDX_1 = 1;
    localparam int REG_IDX_2 = 2;
    localparam int REG_IDX_3 = 3;

    localparam int REG_BYTES = 4;

    // Expands a 4-bit byte strobe into a 32-bit bit mask.
    function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
        logic [31:0] m;
        m = '0;
        for (int k = 0; k < REG_BYTES; k++) begin
            m[k*8 +: 8] = {8{strb[k]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/axil_reg_bank.sv
// Byte-strobed register storage with self-clearing bits.
// A commit updates one register and raises its strobe for one cycle.
module axil_reg_bank
    import lvds_input_common::*;
#(
    parameter int                     NUM_REGS   = 4,
    parameter int                     IDX_W      = 6,
    parameter logic [NUM_REGS*32-1:0] RESET_VAL  = '0,
    parameter logic [NUM_REGS*32-1:0] PULSE_MASK = '0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     we_i,
    input  logic [IDX_W-1:0]         idx_i,
    input  logic [31:0]              data_i,
    input  logic [3:0]               strb_i,
    output logic [NUM_REGS*32-1:0]   regs_o,
    output logic [NUM_REGS-1:0]      pulse_o
);

    logic [NUM_REGS*32-1:0] regs_q;
    logic [NUM_REGS*32-1:0] regs_d;
    logic [NUM_REGS-1:0]    pulse_q;
    logic [NUM_REGS-1:0]    pulse_d;
    logic [31:0]            bmask;

    // Self-clearing bits drop every cycle unless rewritten this cycle.
    always_comb begin
        bmask   = strb_to_mask(strb_i);
        regs_d  = regs_q & ~PULSE_MASK;
        pulse_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (we_i && (idx_i == IDX_W'(i))) begin
                regs_d[i*32 +: 32] = (regs_d[i*32 +: 32] & ~bmask)
                                   | (data_i & bmask);
                pulse_d[i]         = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            regs_q  <= RESET_VAL & ~PULSE_MASK;
            pulse_q <= '0;
        end else begin
            regs_q  <= regs_d;
            pulse_q <= pulse_d;
        end
    end

    assign regs_o  = regs_q;
    assign pulse_o = pulse_q;

endmodule

// File: rtl/axil_reg_write.sv
// AXI-Lite write-only register slave: independent AW/W capture,
// address decode and single-outstanding B response.
module axil_reg_write
    import lvds_input_common::*;
#(
    parameter int                     ADDR_W     = 8,
    parameter int                     NUM_REGS   = 4,
    parameter logic [NUM_REGS*32-1:0] RESET_VAL  = '0,
    parameter logic [NUM_REGS*32-1:0] PULSE_MASK = '0
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic [ADDR_W-1:0]        AWADDR,
    input  logic                     AWVALID,
    output logic                     AWREADY,
    input  logic [31:0]              WDATA,
    input  logic [3:0]               WSTRB,
    input  logic                     WVALID,
    output logic                     WREADY,
    output logic [1:0]               BRESP,
    output logic                     BVALID,
    input  logic                     BREADY,
    output logic [NUM_REGS*32-1:0]   regs,
    output logic [NUM_REGS-1:0]      wr_pulse
);

    localparam int IDX_W = ADDR_W - 2;
    localparam logic [IDX_W:0] NUM_REGS_W = (IDX_W+1)'(NUM_REGS);

    wr_state_e        state_q, state_d;
    logic [IDX_W-1:0] awidx_q, awidx_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic [1:0]       bresp_q, bresp_d;

    logic             aw_hs, w_hs;
    logic             commit;
    logic             in_range;
    logic             bank_we;
    logic [IDX_W-1:0] cur_idx;
    logic [31:0]      cur_data;
    logic [3:0]       cur_strb;
    logic             addr_lsb_unused;

    // Byte offset within a register never affects decode.
    assign addr_lsb_unused = ^AWADDR[1:0];

    assign AWREADY = !ARESET && ((state_q == IDLE) || (state_q == HAVE_W));
    assign WREADY  = !ARESET && ((state_q == IDLE) || (state_q == HAVE_AW));
    assign BVALID  = (state_q == RESP);
    assign BRESP   = bresp_q;

    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID && WREADY;

    always_comb begin
        state_d  = state_q;
        awidx_d  = awidx_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        bresp_d  = bresp_q;
        commit   = 1'b0;
        cur_idx  = awidx_q;
        cur_data = wdata_q;
        cur_strb = wstrb_q;

        // The completing beat may come straight from the bus.
        if (aw_hs) begin
            awidx_d = AWADDR[ADDR_W-1:2];
            cur_idx = AWADDR[ADDR_W-1:2];
        end
        if (w_hs) begin
            wdata_d  = WDATA;
            wstrb_d  = WSTRB;
            cur_data = WDATA;
            cur_strb = WSTRB;
        end

        unique case (state_q)
            IDLE: begin
                if (aw_hs && w_hs) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else if (aw_hs) begin
                    state_d = HAVE_AW;
                end else if (w_hs) begin
                    state_d = HAVE_W;
                end
            end
            HAVE_AW: begin
                if (w_hs) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end
            end
            HAVE_W: begin
                if (aw_hs) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end
            end
            RESP: begin
                if (BREADY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_range = ({1'b0, cur_idx} < NUM_REGS_W);
        bank_we  = commit && in_range;
        if (commit) begin
            bresp_d = in_range ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= IDLE;
            awidx_q <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            bresp_q <= AXI_RESP_OKAY;
        end else begin
            state_q <= state_d;
            awidx_q <= awidx_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            bresp_q <= bresp_d;
        end
    end

    axil_reg_bank #(
        .NUM_REGS   (NUM_REGS),
        .IDX_W      (IDX_W),
        .RESET_VAL  (RESET_VAL),
        .PULSE_MASK (PULSE_MASK)
    ) u_bank (
        .clk_i   (ACLK),
        .rst_i   (ARESET),
        .we_i    (bank_we),
        .idx_i   (cur_idx),
        .data_i  (cur_data),
        .strb_i  (cur_strb),
        .regs_o  (regs),
        .pulse_o (wr_pulse)
    );

endmodule
